// File: rtl/demm_rd_arbiter_pkg.sv
// Shared types and width helpers for the DEMM AXI read-port arbiter.
// Imported by the interface, the round-robin arbiter and the top.
package demm_rd_arbiter_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_outs);
    return $clog2(max_outs) + 1;
  endfunction

  // Widths for the default configuration (NUM_REQ=2, MAX_OUTS=8).
  localparam int unsigned IDX_W = idx_w(2);
  localparam int unsigned CNT_W = cnt_w(8);

  localparam int unsigned ArAddrW = 64;
  localparam int unsigned ArIdW   = 4;

  typedef struct packed {
    logic [ArAddrW-1:0] addr;
    logic [7:0]         len;
    logic [ArIdW-1:0]   id;
  } ar_req_t;

  typedef enum logic [0:0] {StIdle, StIssue} ar_state_e;

endpackage

// File: rtl/demm_rd_arbiter_if.sv
// Requester-side and AXI-master-side read channels of the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface demm_rd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned ID_W    = 4
);
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*8-1:0]      req_arlen;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_rlast;

  logic                      m_arvalid;
  logic                      m_arready;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [ID_W-1:0]           m_arid;
  logic                      m_rvalid;
  logic                      m_rready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_rlast;
  logic [ID_W-1:0]           m_rid;

  modport master (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
    input  m_arready, m_rvalid, m_rdata, m_rlast, m_rid,
    output req_arready, req_rvalid, req_rdata, req_rlast,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast, m_rid,
    input  req_arready, req_rvalid, req_rdata, req_rlast,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );
endinterface

// File: rtl/demm_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
// Kept generic so the write-side arbiter can reuse it.
module rr_arbiter
  import demm_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W_P = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W_P-1:0] ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W_P-1:0] idx_o,
  output logic               any_o
);

  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W_P'(cand);
      end
    end
  end

endmodule

// File: rtl/demm_rd_arbiter.sv
// Shares one AXI4 read port between NUM_REQ DMA requesters: round-robin AR issue
// tagged by requester index, RID-routed R beats, per-requester outstanding caps.
module demm_rd_arbiter
  import demm_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_OUTS = 8
) (
  input  logic               clk,
  input  logic               rstn,
  demm_rd_arbiter_if.master  bus,
  output logic               busy,
  output logic               err_rid
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  localparam int unsigned CntW = cnt_w(MAX_OUTS);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTS);

  ar_state_e         state_q, state_d;
  ar_req_t           ar_q, ar_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q [NUM_REQ];
  logic [CntW-1:0]   cnt_d [NUM_REQ];
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;
  logic               ar_fire;

  logic [IdxW-1:0]    r_idx;
  logic               r_known;
  logic               r_sel_ready;
  logic               r_bad;
  logic               r_ready;
  logic               r_retire;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = bus.req_arvalid[i] && (cnt_q[i] < CntMax);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W_P (IdxW)
  ) u_rr_arbiter (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // AR path: requester handshake latches the burst; m_* come straight from flops.
  always_comb begin
    state_d         = state_q;
    ar_d            = ar_q;
    gnt_idx_d       = gnt_idx_q;
    rr_ptr_d        = rr_ptr_q;
    ar_fire         = 1'b0;
    bus.req_arready = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          bus.req_arready = gnt_oh;
          ar_d.addr       = bus.req_araddr[int'(arb_idx)*ADDR_W +: ADDR_W];
          ar_d.len        = bus.req_arlen[int'(arb_idx)*8 +: 8];
          ar_d.id         = ID_W'(arb_idx);
          gnt_idx_d       = arb_idx;
          state_d         = StIssue;
        end
      end
      StIssue: begin
        if (bus.m_arready) begin
          ar_fire  = 1'b1;
          rr_ptr_d = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.m_arvalid = (state_q == StIssue);
  assign bus.m_araddr  = ar_q.addr;
  assign bus.m_arlen   = ar_q.len;
  assign bus.m_arid    = ar_q.id;

  // R path: unknown or unexpected RIDs are swallowed so the slave never stalls.
  always_comb begin
    r_idx       = bus.m_rid[IdxW-1:0];
    r_known     = 1'b0;
    r_sel_ready = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_idx == IdxW'(i)) begin
        r_known     = (cnt_q[i] != '0);
        r_sel_ready = bus.req_rready[i];
      end
    end
    r_bad    = ({1'b0, bus.m_rid} >= (ID_W + 1)'(NUM_REQ)) || !r_known;
    r_ready  = r_bad ? 1'b1 : r_sel_ready;
    r_retire = bus.m_rvalid && r_ready && bus.m_rlast && !r_bad;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_rvalid[i] = bus.m_rvalid && !r_bad && (r_idx == IdxW'(i));
    end
    err_d = err_q | (bus.m_rvalid & r_bad);
  end

  assign bus.m_rready  = r_ready;
  assign bus.req_rdata = bus.m_rdata;
  assign bus.req_rlast = bus.m_rlast;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      logic inc, dec;
      inc      = ar_fire && (gnt_idx_q == IdxW'(i));
      dec      = r_retire && (r_idx == IdxW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_comb begin
    busy = (state_q == StIssue);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

  assign err_rid = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      ar_q      <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      for (int i = 0; i < int'(NUM_REQ); i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_demm_rd_arbiter.sv
// Directed bench for demm_rd_arbiter; expected AR bursts and R beats are queued
// by the stimulus and checked by independent monitors on the falling edge.
module tb_demm_rd_arbiter;
  import demm_rd_arbiter_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned IW = 4;
  localparam int unsigned MO = 8;

  typedef struct {
    int             idx;
    logic [DW-1:0]  data;
    logic           last;
  } r_exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic busy;
  logic err_rid;

  always #5 clk = ~clk;

  demm_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  demm_rd_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .ID_W     (IW),
    .MAX_OUTS (MO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .busy    (busy),
    .err_rid (err_rid)
  );

  int checks   = 0;
  int failures = 0;

  ar_req_t ar_exp[$];
  r_exp_t  r_exp[$];
  ar_req_t ar_mon;
  r_exp_t  r_mon;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // AR monitor: every master AR handshake must match the next queued burst.
  always @(negedge clk) begin
    if (rstn && bus.m_arvalid && bus.m_arready) begin
      if (ar_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ar_unexpected actual=addr %0h required=none", bus.m_araddr);
      end else begin
        ar_mon = ar_exp.pop_front();
        chk("ar_addr", DW'(bus.m_araddr), DW'(ar_mon.addr));
        chk("ar_len", DW'(bus.m_arlen), DW'(ar_mon.len));
        chk("ar_id", DW'(bus.m_arid), DW'(ar_mon.id));
      end
    end
  end

  // R monitor: every requester-side R handshake must match the next queued beat.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < int'(NR); i++) begin
        if (bus.req_rvalid[i] && bus.req_rready[i]) begin
          if (r_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_unexpected actual=req %0d required=none", i);
          end else begin
            r_mon = r_exp.pop_front();
            chk("r_route", DW'(i), DW'(r_mon.idx));
            chk("r_data", bus.req_rdata, r_mon.data);
            chk("r_last", DW'(bus.req_rlast), DW'(r_mon.last));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arlen   = '0;
    bus.req_rready  = '0;
    bus.m_arready   = 1'b1;
    bus.m_rvalid    = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rlast     = 1'b0;
    bus.m_rid       = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  // Waits for req r to be granted while its arvalid is held; queues the AR expectation.
  task automatic wait_grant(input int r, input logic [AW-1:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.req_arready[r]) begin
        ar_exp.push_back('{addr: addr, len: len, id: IW'(r)});
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout actual=no grant required=grant req %0d", r);
    end
  endtask

  task automatic issue_ar(input int r, input logic [AW-1:0] addr, input logic [7:0] len);
    bus.req_araddr[r*AW +: AW] = addr;
    bus.req_arlen[r*8 +: 8]    = len;
    bus.req_arvalid[r]         = 1'b1;
    wait_grant(r, addr, len);
    bus.req_arvalid[r] = 1'b0;
  endtask

  task automatic send_beat(input int rid, input logic [DW-1:0] data, input bit last);
    bit ok = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rid    = IW'(rid);
    bus.m_rdata  = data;
    bus.m_rlast  = last;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.m_rready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=m_rready low required=beat rid %0d taken", rid);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int b);
    return {16{32'hC0DE_0000 | 32'(b)}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq [4] = '{0, 1, 0, 1};
    int n;

    // Reset state
    rstn = 1'b0;
    clear_inputs();
    #12;
    chk("rst_m_arvalid", DW'(bus.m_arvalid), DW'(0));
    chk("rst_req_arready", DW'(bus.req_arready), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_err_rid", DW'(err_rid), DW'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();

    // Single burst: AR one cycle after grant, 16 beats, busy drops after rlast
    issue_ar(0, 64'h1000_0000, 8'd15);
    chk("t1_m_arvalid", DW'(bus.m_arvalid), DW'(1));
    chk("t1_m_arid", DW'(bus.m_arid), DW'(0));
    step();
    chk("t1_busy_outstanding", DW'(busy), DW'(1));
    bus.req_rready[0] = 1'b1;
    for (int b = 0; b < 16; b++) begin
      r_exp.push_back('{idx: 0, data: pat(b), last: (b == 15)});
      send_beat(0, pat(b), b == 15);
    end
    chk("t1_busy_done", DW'(busy), DW'(0));
    chk("t1_r_drained", DW'(r_exp.size()), DW'(0));

    // Both requesters valid: grants alternate 0,1,0,1
    do_reset();
    bus.req_araddr = {64'h3000, 64'h2000};
    bus.req_arlen  = {8'd7, 8'd3};
    bus.req_arvalid = 2'b11;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      #1;
      if (bus.req_arready != '0) begin
        chk("alt_grant", DW'(bus.req_arready), DW'(NR'(1) << exp_seq[n]));
        ar_exp.push_back('{addr: (exp_seq[n] == 0) ? 64'h2000 : 64'h3000,
                           len: (exp_seq[n] == 0) ? 8'd3 : 8'd7,
                           id: IW'(exp_seq[n])});
        n++;
      end
      step();
    end
    bus.req_arvalid = '0;
    chk("alt_count", DW'(n), DW'(4));
    repeat (2) step();
    chk("alt_ar_drained", DW'(ar_exp.size()), DW'(0));

    // Outstanding cap: 9th AR from req0 blocked, req1 still served, retire unblocks
    do_reset();
    for (int k = 0; k < 8; k++) issue_ar(0, 64'h4000 + 64'(k * 256), 8'd0);
    repeat (2) step();
    bus.req_araddr[0 +: AW] = 64'h5000;
    bus.req_arlen[0 +: 8]   = 8'd0;
    bus.req_arvalid[0]      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("cap_blocked", DW'(bus.req_arready[0]), DW'(0));
      step();
    end
    issue_ar(1, 64'h6000, 8'd1);
    chk("cap_req1_issue", DW'(bus.m_arid), DW'(1));
    bus.req_rready[0] = 1'b1;
    r_exp.push_back('{idx: 0, data: pat(100), last: 1'b1});
    send_beat(0, pat(100), 1'b1);
    wait_grant(0, 64'h5000, 8'd0);
    bus.req_arvalid[0] = 1'b0;
    repeat (2) step();
    chk("cap_ar_drained", DW'(ar_exp.size()), DW'(0));

    // Interleaved R with req1 back-pressuring: beat held, nothing lost
    do_reset();
    issue_ar(0, 64'h7000, 8'd0);
    issue_ar(1, 64'h8000, 8'd1);
    repeat (2) step();
    bus.req_rready = 2'b01;
    bus.m_rvalid   = 1'b1;
    bus.m_rid      = IW'(1);
    bus.m_rdata    = pat(201);
    bus.m_rlast    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("il_m_rready_low", DW'(bus.m_rready), DW'(0));
      chk("il_req_rvalid", DW'(bus.req_rvalid), DW'(2'b10));
      chk("il_data_held", bus.req_rdata, pat(201));
      step();
    end
    bus.req_rready = 2'b11;
    r_exp.push_back('{idx: 1, data: pat(201), last: 1'b0});
    send_beat(1, pat(201), 1'b0);
    r_exp.push_back('{idx: 0, data: pat(202), last: 1'b1});
    send_beat(0, pat(202), 1'b1);
    r_exp.push_back('{idx: 1, data: pat(203), last: 1'b1});
    send_beat(1, pat(203), 1'b1);
    chk("il_busy_done", DW'(busy), DW'(0));
    chk("il_r_drained", DW'(r_exp.size()), DW'(0));

    // Bad RID: out of range, then in range but nothing outstanding
    do_reset();
    bus.req_rready = 2'b11;
    bus.m_rvalid   = 1'b1;
    bus.m_rid      = IW'(3);
    bus.m_rlast    = 1'b1;
    bus.m_rdata    = pat(300);
    #1;
    chk("bad_rid_ready", DW'(bus.m_rready), DW'(1));
    chk("bad_rid_no_rvalid", DW'(bus.req_rvalid), DW'(0));
    step();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    chk("bad_rid_err", DW'(err_rid), DW'(1));
    chk("bad_rid_busy", DW'(busy), DW'(0));
    issue_ar(0, 64'h9000, 8'd0);
    repeat (2) step();
    send_beat(2, pat(301), 1'b1);
    chk("bad_rid_cnt_kept", DW'(busy), DW'(1));
    r_exp.push_back('{idx: 0, data: pat(302), last: 1'b1});
    send_beat(0, pat(302), 1'b1);
    chk("bad_rid_retired", DW'(busy), DW'(0));
    chk("bad_rid_sticky", DW'(err_rid), DW'(1));

    // Same-cycle AR issue and retire on req0: count stays at one
    do_reset();
    chk("err_cleared_by_reset", DW'(err_rid), DW'(0));
    issue_ar(0, 64'hA000, 8'd0);
    repeat (2) step();
    bus.m_arready = 1'b0;
    issue_ar(0, 64'hB000, 8'd0);
    step();
    chk("sc_held_issue", DW'(bus.m_arvalid), DW'(1));
    bus.m_arready     = 1'b1;
    bus.req_rready[0] = 1'b1;
    bus.m_rvalid      = 1'b1;
    bus.m_rid         = IW'(0);
    bus.m_rlast       = 1'b1;
    bus.m_rdata       = pat(400);
    r_exp.push_back('{idx: 0, data: pat(400), last: 1'b1});
    #1;
    chk("sc_m_rready", DW'(bus.m_rready), DW'(1));
    step();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    chk("sc_busy_one_left", DW'(busy), DW'(1));
    r_exp.push_back('{idx: 0, data: pat(401), last: 1'b1});
    send_beat(0, pat(401), 1'b1);
    chk("sc_busy_done", DW'(busy), DW'(0));
    chk("sc_no_err", DW'(err_rid), DW'(0));

    // Asynchronous reset while an AR sits in ISSUE with another outstanding
    do_reset();
    issue_ar(0, 64'hC000, 8'd0);
    repeat (2) step();
    bus.m_arready = 1'b0;
    issue_ar(0, 64'hC100, 8'd3);
    chk("ar_rst_pre_valid", DW'(bus.m_arvalid), DW'(1));
    chk("ar_rst_pre_busy", DW'(busy), DW'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_rst_m_arvalid", DW'(bus.m_arvalid), DW'(0));
    chk("ar_rst_busy", DW'(busy), DW'(0));
    ar_exp.delete();
    step();
    rstn = 1'b1;
    bus.m_arready = 1'b1;
    step();
    chk("ar_rst_after_busy", DW'(busy), DW'(0));

    chk("final_ar_drained", DW'(ar_exp.size()), DW'(0));
    chk("final_r_drained", DW'(r_exp.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
